// File: rtl/ddr2_init_refresh_seq.sv
// ddr2_init_refresh_seq
//   Drives the DDR2 power-up/initialisation command sequence, then hands the
//   command bus to the controller and schedules periodic auto-refresh bursts
//   (PRECHARGE ALL followed by REFRESH) whenever the controller grants the bus.
//
// Ports
//   clk        : single rising-edge clock
//   rst_n      : synchronous active-low reset; restarts the full init sequence
//   ref_ack    : controller grants the bus for a refresh (banks are idle)
//   cke, cs_n, ras_n, cas_n, we_n, ba[2:0], addr[12:0] : DDR2 command bus
//   own_bus    : high while this block drives the command bus
//   init_done  : sticky, high once the init sequence has completed
//   ref_req    : at least one refresh is pending
//   ref_err    : sticky, a refresh interval expired with 8 already pending
//   dbg_state  : current sequencer state, for observation only
//
// Handshake: ref_req is a level that stays high while pending != 0. A grant
// is taken only in IDLE, on a cycle where ref_req && ref_ack are both high;
// the PRECHARGE goes out on the following cycle. ref_ack is ignored in any
// other state.
module ddr2_init_refresh_seq #(
    parameter int unsigned T_INIT    = 200,
    parameter int unsigned T_XPR     = 80,
    parameter int unsigned T_RP      = 4,
    parameter int unsigned T_MRD     = 2,
    parameter int unsigned T_RFC     = 26,
    parameter int unsigned T_DLL     = 200,
    parameter int unsigned T_REFI    = 1560,
    parameter logic [12:0] MR_VALUE  = 13'h0032,
    parameter logic [12:0] EMR_VALUE = 13'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ref_ack,
    output logic        cke,
    output logic        cs_n,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [2:0]  ba,
    output logic [12:0] addr,
    output logic        own_bus,
    output logic        init_done,
    output logic        ref_req,
    output logic        ref_err,
    output logic [3:0]  dbg_state
);

    // Wait counter must hold the longest wait minus one without wrapping.
    localparam int unsigned T_MAX_0 = (T_INIT > T_XPR) ? T_INIT : T_XPR;
    localparam int unsigned T_MAX_1 = (T_MAX_0 > T_RP) ? T_MAX_0 : T_RP;
    localparam int unsigned T_MAX_2 = (T_MAX_1 > T_MRD) ? T_MAX_1 : T_MRD;
    localparam int unsigned T_MAX_3 = (T_MAX_2 > T_RFC) ? T_MAX_2 : T_RFC;
    localparam int unsigned T_MAX   = (T_MAX_3 > T_DLL) ? T_MAX_3 : T_DLL;
    localparam int CW = $clog2(T_MAX + 1);
    localparam int RW = $clog2(T_REFI + 1);
    localparam logic [RW-1:0] REFI_RELOAD = RW'(T_REFI - 1);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [3:0] {
        S_RESET, S_CKE, S_PRE_A, S_EMRS2, S_EMRS3, S_EMRS1_DLL, S_MRS_RST,
        S_PRE_B, S_REF_A, S_REF_B, S_MRS, S_EMRS1_OCD, S_EMRS1_EXIT,
        S_IDLE, S_RF_PRE, S_RF_REF
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_last;
    int unsigned     w_len;
    logic            w_at_end;
    logic [3:0]      w_cmd;
    logic [RW-1:0]   r_refcnt;
    logic [3:0]      r_pending;
    logic            r_init_done;
    logic            r_ref_err;
    logic            w_expire;
    logic            w_ref_done;
    logic            w_enter_idle;

    assign ref_req   = (r_pending != 4'd0) && r_init_done;
    assign init_done = r_init_done;
    assign ref_err   = r_ref_err;
    assign dbg_state = r_state;
    assign {cs_n, ras_n, cas_n, we_n} = w_cmd;

    assign w_at_end     = (r_cnt == w_last);
    assign w_expire     = r_init_done && (r_refcnt == '0);
    assign w_ref_done   = (r_state == S_RF_REF) && w_at_end;
    assign w_enter_idle = (r_state == S_EMRS1_EXIT) && w_at_end;

    // Each state lasts w_len cycles: command on its first cycle (r_cnt == 0),
    // NOPs for the rest.
    always_comb begin
        w_len = T_MRD;
        unique case (r_state)
            S_RESET:                      w_len = T_INIT;
            S_CKE:                        w_len = T_XPR;
            S_PRE_A, S_PRE_B, S_RF_PRE:   w_len = T_RP;
            S_REF_A, S_REF_B, S_RF_REF:   w_len = T_RFC;
            S_EMRS1_EXIT:                 w_len = T_DLL;
            S_IDLE:                       w_len = 1;
            default:                      w_len = T_MRD;
        endcase
        w_last = CW'(w_len - 1);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_state == S_IDLE) begin
            w_cnt_nxt = '0;
            if (ref_req && ref_ack) w_state_nxt = S_RF_PRE;
        end else if (w_at_end) begin
            w_cnt_nxt = '0;
            unique case (r_state)
                S_RESET:      w_state_nxt = S_CKE;
                S_CKE:        w_state_nxt = S_PRE_A;
                S_PRE_A:      w_state_nxt = S_EMRS2;
                S_EMRS2:      w_state_nxt = S_EMRS3;
                S_EMRS3:      w_state_nxt = S_EMRS1_DLL;
                S_EMRS1_DLL:  w_state_nxt = S_MRS_RST;
                S_MRS_RST:    w_state_nxt = S_PRE_B;
                S_PRE_B:      w_state_nxt = S_REF_A;
                S_REF_A:      w_state_nxt = S_REF_B;
                S_REF_B:      w_state_nxt = S_MRS;
                S_MRS:        w_state_nxt = S_EMRS1_OCD;
                S_EMRS1_OCD:  w_state_nxt = S_EMRS1_EXIT;
                S_EMRS1_EXIT: w_state_nxt = S_IDLE;
                S_RF_PRE:     w_state_nxt = S_RF_REF;
                S_RF_REF:     w_state_nxt = S_IDLE;
                default:      w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Command bus decode
    always_comb begin
        cke     = 1'b1;
        w_cmd   = CMD_NOP;
        ba      = 3'd0;
        addr    = 13'd0;
        own_bus = 1'b1;
        unique case (r_state)
            S_RESET: begin
                cke   = 1'b0;
                w_cmd = CMD_DESEL;
            end
            S_IDLE: own_bus = 1'b0;
            S_PRE_A, S_PRE_B, S_RF_PRE: if (r_cnt == '0) begin
                w_cmd = CMD_PRE;
                addr  = 13'h0400;   // A10 selects all banks
            end
            S_REF_A, S_REF_B, S_RF_REF: if (r_cnt == '0) w_cmd = CMD_REF;
            S_EMRS2: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                ba    = 3'd2;
            end
            S_EMRS3: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                ba    = 3'd3;
            end
            S_EMRS1_DLL, S_EMRS1_EXIT: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                ba    = 3'd1;
                addr  = EMR_VALUE;
            end
            S_EMRS1_OCD: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                ba    = 3'd1;
                addr  = EMR_VALUE | 13'h0380;   // OCD calibration default
            end
            S_MRS_RST: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                addr  = MR_VALUE | 13'h0100;    // DLL reset
            end
            S_MRS: if (r_cnt == '0) begin
                w_cmd = CMD_MRS;
                addr  = MR_VALUE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_cnt       <= '0;
            r_refcnt    <= '0;
            r_pending   <= 4'd0;
            r_init_done <= 1'b0;
            r_ref_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;

            // Interval timer runs from init completion on, including bursts.
            if (w_enter_idle) begin
                r_init_done <= 1'b1;
                r_refcnt    <= REFI_RELOAD;
            end else if (r_init_done) begin
                r_refcnt <= w_expire ? REFI_RELOAD : r_refcnt - 1'b1;
            end

            // An expiry and a completed refresh in the same cycle cancel out.
            unique case ({w_expire, w_ref_done})
                2'b10: begin
                    if (r_pending == 4'd8) r_ref_err <= 1'b1;
                    else                   r_pending <= r_pending + 4'd1;
                end
                2'b01:   r_pending <= r_pending - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ddr2_init_refresh_seq.md
DDR2_INIT_REFRESH_SEQ -- requirements
Module: ddr2_init_refresh_seq

Interface
REQ-001 The block SHALL have parameter T_INIT, default 200: clock cycles with CKE low after reset release.
REQ-002 The block SHALL have parameter T_XPR, default 80: NOP cycles after CKE rises, before the first command.
REQ-003 The block SHALL have parameter T_RP, default 4: command spacing after PRECHARGE ALL.
REQ-004 The block SHALL have parameter T_MRD, default 2: command spacing after MRS/EMRS.
REQ-005 The block SHALL have parameter T_RFC, default 26: command spacing after REFRESH.
REQ-006 The block SHALL have parameter T_DLL, default 200: cycles from the last EMRS1 to init_done.
REQ-007 The block SHALL have parameter T_REFI, default 1560: refresh interval in cycles.
REQ-008 The block SHALL have parameter MR_VALUE, default 13'h0032 (BL4, CL3), and parameter EMR_VALUE, default 13'h0000 (DLL on, ODT off).
REQ-009 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-010 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-011 The block SHALL have port ref_ack, input, 1 bit: the controller grants the bus for refresh (banks idle).
REQ-012 The block SHALL have ports cke, cs_n, ras_n, cas_n, we_n, each output, 1 bit: DDR2 command bus.
REQ-013 The block SHALL have port ba, output, 3 bits, and port addr, output, 13 bits: DDR2 bank and address.
REQ-014 The block SHALL have port own_bus, output, 1 bit: high while this block drives the command bus.
REQ-015 The block SHALL have port init_done, output, 1 bit: sticky high after init; drives the memory model's load_memory.
REQ-016 The block SHALL have port ref_req, output, 1 bit: a refresh is pending.
REQ-017 The block SHALL have port ref_err, output, 1 bit: sticky flag, pending refresh count overflowed.

Function
REQ-018 Command encodings {cs_n,ras_n,cas_n,we_n} SHALL be: NOP 0111, PRE 0010 with addr[10]=1, REF 0001, MRS 0000 with ba selecting MR/EMR1/EMR2/EMR3; NOP outputs ba=0, addr=0.
REQ-019 Spacing rule: a command with parameter P SHALL occupy 1 cycle and be followed by P-1 NOP cycles.
REQ-020 Init FSM order: RESET (cke=0, cs_n=1, T_INIT cycles) -> CKE (cke=1, NOP, T_XPR) -> PRE/T_RP -> EMRS2 (ba=2, addr=0)/T_MRD -> EMRS3 (ba=3, addr=0)/T_MRD -> EMRS1 (ba=1, EMR_VALUE)/T_MRD -> MRS (ba=0, MR_VALUE|13'h0100)/T_MRD -> PRE/T_RP -> REF/T_RFC -> REF/T_RFC -> MRS (ba=0, MR_VALUE)/T_MRD -> EMRS1 (EMR_VALUE|13'h0380)/T_MRD -> EMRS1 (EMR_VALUE)/T_DLL -> IDLE.
REQ-021 On entering IDLE, init_done SHALL go high, own_bus SHALL go low, and the refresh counter SHALL load T_REFI-1.
REQ-022 In IDLE the refresh counter SHALL decrement each cycle and, on reaching 0, reload T_REFI-1 and increment a 4-bit pending count, saturating at 8.
REQ-023 An expiry while pending=8 SHALL set ref_err; pending SHALL stay 8.
REQ-024 ref_req SHALL equal (pending != 0) && init_done.
REQ-025 When ref_req && ref_ack in IDLE, on the next cycle own_bus SHALL go high and the block SHALL issue PRE/T_RP then REF/T_RFC, decrement pending, and return to IDLE with own_bus low.
REQ-026 Expiry in the same cycle as the REF-completion decrement SHALL leave pending unchanged.
REQ-027 ref_ack SHALL be ignored outside IDLE and when pending=0.
REQ-028 While own_bus=0, command outputs SHALL hold NOP with cke=1.
REQ-029 The refresh counter SHALL keep running during a refresh burst.
REQ-030 Counters SHALL be sized from the parameters with no wrap; all waits are exact.

Reset
REQ-031 While rst_n=0 at a clock edge, the next state SHALL be: cke=0, cs_n=1, ras_n=cas_n=we_n=1, ba=0, addr=0, own_bus=1, init_done=0, ref_req=0, ref_err=0, pending=0, FSM=RESET with its counter cleared.
REQ-032 Reset asserted mid-sequence or mid-refresh SHALL abort immediately; the full init SHALL rerun from RESET.

Verification
REQ-033 The bench SHALL cover: default params, rst_n released at cycle 0 -> cke rises at cycle 200; PRE at 280; EMRS2 284, EMRS3 286, EMRS1 288, MRS(addr=0x0132) 290, PRE 292, REF 296, REF 322, MRS(addr=0x0032) 348, EMRS1(addr=0x0380) 350, EMRS1(addr=0) 352, init_done high at 552.
REQ-034 The bench SHALL cover: ref_ack tied high after init -> ref_req rises 1560 cycles after init_done; PRE next cycle; REF 4 cycles later; own_bus low 26 cycles after REF.
REQ-035 The bench SHALL cover: ref_ack held low for 9*T_REFI after init -> pending saturates at 8, ref_err=1 after the 9th expiry; then ack -> 8 PRE/REF pairs before ref_req falls.
REQ-036 The bench SHALL cover: rst_n pulled low for 1 cycle at cycle 300 -> cke=0 on the next cycle; cke rises again 200 cycles after release; init_done stays 0 until the full rerun completes.
REQ-037 The bench SHALL cover: expiry coinciding with the REF-completion cycle at pending=1 -> pending remains 1 and ref_req stays high.
REQ-038 The bench SHALL cover: ref_ack pulsed during init -> no effect; the command trace is identical to REQ-033.
